// File: rtl/id_ex_pipe_pkg.sv
// Shared widths and control-bundle bit positions for the ID/EX pipeline register.
package id_ex_pipe_pkg;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 10;
  localparam int REG_W  = 5;
  localparam int CNT_W  = 16;

  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMREAD   = 8;
  localparam int CTRL_MEMWRITE  = 7;
  localparam int CTRL_MEMTOREG  = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_ALUOP_MSB = 2;
  localparam int CTRL_ALUOP_LSB = 0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import id_ex_pipe_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_memread_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  output logic             load_use_o
);
  // $zero never carries a real dependency, so a load targeting it never stalls.
  assign load_use_o = ex_valid_i & ex_memread_i & (ex_rt_i != '0) & id_valid_i &
                      ((ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i));
endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with flush, downstream hold, load-use bubble insertion
// and a saturating count of inserted bubbles.
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int DATA_W = id_ex_pipe_pkg::DATA_W,
  parameter int CTRL_W = id_ex_pipe_pkg::CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_pc_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  input  logic [REG_W-1:0]  id_rd_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_pc_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_W-1:0]  ex_rs_o,
  output logic [REG_W-1:0]  ex_rt_o,
  output logic [REG_W-1:0]  ex_rd_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic              load_use;

  hazard_detect u_hazard_detect (
    .ex_valid_i   (valid_q),
    .ex_memread_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i      (rt_q),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .load_use_o   (load_use)
  );

  // A flush squashes the stalled instruction anyway, so it overrides any freeze.
  assign stall_o = (load_use | hold_i) & ~flush_i;

  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    ctrl_d       = ctrl_q;
    bubble_cnt_d = bubble_cnt_q;
    if (flush_i || (!hold_i && load_use)) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      ctrl_d    = '0;
      if (!flush_i) bubble_cnt_d = sat_inc(bubble_cnt_q);
    end else if (!hold_i) begin
      valid_d   = id_valid_i;
      pc_d      = id_pc_i;
      rs_data_d = id_rs_data_i;
      rt_data_d = id_rt_data_i;
      imm_d     = id_imm_i;
      rs_d      = id_rs_i;
      rt_d      = id_rt_i;
      rd_d      = id_rd_i;
      ctrl_d    = id_valid_i ? id_ctrl_i : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
      ctrl_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
      ctrl_q       <= ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid_o   = valid_q;
  assign ex_pc_o      = pc_q;
  assign ex_rs_data_o = rs_data_q;
  assign ex_rt_data_o = rt_data_q;
  assign ex_imm_o     = imm_q;
  assign ex_rs_o      = rs_q;
  assign ex_rt_o      = rt_q;
  assign ex_rd_o      = rd_q;
  assign ex_ctrl_o    = ctrl_q;
  assign bubble_cnt_o = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// Table-driven bench for id_ex_pipe: each vector's expected EX contents are queued
// when driven and compared after the following clock edge.
module tb_id_ex_pipe;
  localparam logic [9:0] LW  = 10'b1101100000;
  localparam logic [9:0] ADD = 10'b1000110010;

  typedef enum logic [1:0] {K_CAP, K_ZERO, K_KEEP} kind_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic [9:0]  ctrl;
    logic [15:0] cnt;
  } out_t;

  typedef struct {
    logic        flush, hold, valid;
    logic [9:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        stall;
    kind_e       kind;
    logic [15:0] cnt;
  } vec_t;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        flush = 1'b0, hold = 1'b0, id_valid = 1'b0;
  logic [31:0] id_pc = '0, id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
  logic [9:0]  id_ctrl = '0;
  logic        ex_valid, stall;
  logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [9:0]  ex_ctrl;
  logic [15:0] bubble_cnt;

  int   n_checks = 0, n_fail = 0;
  out_t sb[$];
  out_t exp_prev = '0;
  vec_t tbl[$];
  vec_t sat[$];

  id_ex_pipe dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .hold_i(hold), .id_valid_i(id_valid),
    .id_pc_i(id_pc), .id_rs_data_i(id_rs_data), .id_rt_data_i(id_rt_data), .id_imm_i(id_imm),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd), .id_ctrl_i(id_ctrl),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_rs_data_o(ex_rs_data), .ex_rt_data_o(ex_rt_data),
    .ex_imm_o(ex_imm), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_rd_o(ex_rd), .ex_ctrl_o(ex_ctrl),
    .stall_o(stall), .bubble_cnt_o(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic fl, input logic ho, input logic va, input logic [9:0] ct,
                              input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                              input logic [31:0] imm, input logic st, input kind_e k,
                              input logic [15:0] cnt);
    vec_t t;
    t.flush = fl; t.hold = ho; t.valid = va; t.ctrl = ct;
    t.rs = rs; t.rt = rt; t.rd = rd; t.imm = imm;
    t.stall = st; t.kind = k; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h exp=%h", name, idx, got, exp);
    end
  endtask

  task automatic cmp_out(input out_t e, input int idx);
    chk("ex_valid", idx, {31'd0, ex_valid}, {31'd0, e.valid});
    chk("ex_pc", idx, ex_pc, e.pc);
    chk("ex_rs_data", idx, ex_rs_data, e.rs_data);
    chk("ex_rt_data", idx, ex_rt_data, e.rt_data);
    chk("ex_imm", idx, ex_imm, e.imm);
    chk("ex_rs", idx, {27'd0, ex_rs}, {27'd0, e.rs});
    chk("ex_rt", idx, {27'd0, ex_rt}, {27'd0, e.rt});
    chk("ex_rd", idx, {27'd0, ex_rd}, {27'd0, e.rd});
    chk("ex_ctrl", idx, {22'd0, ex_ctrl}, {22'd0, e.ctrl});
    chk("bubble_cnt", idx, {16'd0, bubble_cnt}, {16'd0, e.cnt});
  endtask

  task automatic apply(input vec_t t, input int idx);
    out_t e;
    @(negedge clk);
    flush = t.flush; hold = t.hold; id_valid = t.valid; id_ctrl = t.ctrl;
    id_rs = t.rs; id_rt = t.rt; id_rd = t.rd; id_imm = t.imm;
    id_pc = 32'h0000_1000 + 32'(idx) * 32'd4;
    id_rs_data = 32'hA000_0000 | 32'(idx);
    id_rt_data = 32'hB000_0000 | 32'(idx);
    #1;
    chk("stall", idx, {31'd0, stall}, {31'd0, t.stall});
    case (t.kind)
      K_CAP:   e = '{valid: t.valid, pc: id_pc, rs_data: id_rs_data, rt_data: id_rt_data,
                     imm: t.imm, rs: t.rs, rt: t.rt, rd: t.rd,
                     ctrl: (t.valid ? t.ctrl : 10'd0), cnt: 16'd0};
      K_ZERO:  e = '0;
      default: e = exp_prev;
    endcase
    e.cnt = t.cnt;
    sb.push_back(e);
    exp_prev = e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_empty[%0d] got=0 exp=1", idx);
    end else begin
      cmp_out(sb.pop_front(), idx);
    end
  endtask

  initial begin
    //          fl   ho   va   ctrl rs  rt  rd  imm            stall kind    cnt
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 1, 2, 3, 32'hFFFF_FFFC, 1'b0, K_CAP,  16'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,LW,  4, 8, 0, 32'h0000_0010, 1'b0, K_CAP,  16'd0));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 8, 9,10, 32'h0000_0000, 1'b1, K_ZERO, 16'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 8, 9,10, 32'h0000_0000, 1'b0, K_CAP,  16'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,LW,  2, 0, 0, 32'h0000_0020, 1'b0, K_CAP,  16'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 0, 0,11, 32'h0000_0000, 1'b0, K_CAP,  16'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,LW,  0, 5, 0, 32'h0000_0030, 1'b0, K_CAP,  16'd1));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 1, 5,12, 32'h0000_0000, 1'b1, K_ZERO, 16'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,LW,  1, 7, 0, 32'h0000_0040, 1'b0, K_CAP,  16'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b0,ADD, 7, 1,13, 32'h0000_1234, 1'b0, K_CAP,  16'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,LW,  1, 6, 0, 32'h0000_0050, 1'b0, K_CAP,  16'd2));
    tbl.push_back(mk(1'b1,1'b0,1'b1,ADD, 6, 1,14, 32'h0000_0000, 1'b0, K_ZERO, 16'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,LW,  1, 3, 0, 32'h0000_0060, 1'b0, K_CAP,  16'd2));
    tbl.push_back(mk(1'b0,1'b1,1'b1,ADD, 3, 1,15, 32'h0000_0000, 1'b1, K_KEEP, 16'd2));
    tbl.push_back(mk(1'b0,1'b1,1'b1,ADD, 3, 1,15, 32'h0000_0000, 1'b1, K_KEEP, 16'd2));
    tbl.push_back(mk(1'b0,1'b1,1'b1,ADD, 3, 1,15, 32'h0000_0000, 1'b1, K_KEEP, 16'd2));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 3, 1,15, 32'h0000_0000, 1'b1, K_ZERO, 16'd3));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 3, 1,15, 32'h0000_0000, 1'b0, K_CAP,  16'd3));
    tbl.push_back(mk(1'b1,1'b1,1'b1,LW,  1, 8, 0, 32'h0000_0070, 1'b0, K_ZERO, 16'd3));
    tbl.push_back(mk(1'b0,1'b0,1'b0,LW,  1, 8, 0, 32'h0000_0080, 1'b0, K_CAP,  16'd3));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 8, 8,16, 32'h0000_0000, 1'b0, K_CAP,  16'd3));
    tbl.push_back(mk(1'b0,1'b0,1'b1,LW,  1, 9, 0, 32'h0000_0090, 1'b0, K_CAP,  16'd3));
    tbl.push_back(mk(1'b0,1'b0,1'b1,ADD, 1, 2,17, 32'h0000_0000, 1'b0, K_CAP,  16'd3));

    sat.push_back(mk(1'b0,1'b0,1'b1,LW,  1, 8, 0, 32'h0000_00A0, 1'b0, K_CAP,  16'hFFFE));
    sat.push_back(mk(1'b0,1'b0,1'b1,ADD, 8, 2,18, 32'h0000_0000, 1'b1, K_ZERO, 16'hFFFF));
    sat.push_back(mk(1'b0,1'b0,1'b1,LW,  1, 8, 0, 32'h0000_00B0, 1'b0, K_CAP,  16'hFFFF));
    sat.push_back(mk(1'b0,1'b0,1'b1,ADD, 2, 8,19, 32'h0000_0000, 1'b1, K_ZERO, 16'hFFFF));
    sat.push_back(mk(1'b0,1'b0,1'b1,ADD, 5, 6,20, 32'h0000_C0DE, 1'b0, K_CAP,  16'hFFFF));

    #3;
    cmp_out('0, -1);
    chk("stall_reset", -1, {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], i);

    @(negedge clk);
    force dut.bubble_cnt_q = 16'hFFFE;
    #1;
    release dut.bubble_cnt_q;
    #1;
    chk("bubble_cnt_preload", 100, {16'd0, bubble_cnt}, 32'h0000_FFFE);
    foreach (sat[i]) apply(sat[i], 200 + i);

    // Reset asserted mid-cycle while a hold is pending; outputs clear before any edge.
    @(negedge clk);
    hold = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    cmp_out('0, 300);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    hold = 1'b0;
    exp_prev = '0;
    apply(mk(1'b0,1'b0,1'b1,ADD, 3, 4, 5, 32'hFFFF_FFFC, 1'b0, K_CAP, 16'd0), 301);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, 32, datapath width.
REQ-002 SHALL have parameter CTRL_W, 10, control bundle width: {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegDst, Branch, ALUOp[2:0]}, MSB first.
REQ-003 SHALL have clk_i  in  1  system clock, all state on rising edge.
REQ-004 SHALL have rst_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have flush_i  in  1  squash ID/EX contents (taken branch resolved in EX).
REQ-006 SHALL have hold_i  in  1  downstream freeze; keep ID/EX contents unchanged.
REQ-007 SHALL have id_valid_i  in  1  ID slot holds a real instruction.
REQ-008 SHALL have id_pc_i, id_rs_data_i, id_rt_data_i, id_imm_i  in  DATA_W each  PC+4, register operands, sign-extended immediate.
REQ-009 SHALL have id_rs_i, id_rt_i, id_rd_i  in  5 each  register indices.
REQ-010 SHALL have id_ctrl_i  in  CTRL_W  decoded control bundle.
REQ-011 SHALL have ex_valid_o, ex_pc_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o, ex_ctrl_o  out  widths matching inputs  registered ID/EX contents.
REQ-012 SHALL have stall_o  out  1  combinational; freeze PC and IF/ID.
REQ-013 SHALL have bubble_cnt_o  out  16  registered count of load-use bubbles inserted.

Function
REQ-014 SHALL compute load_use = ex_valid_o & ex_ctrl_o.MemRead & (ex_rt_o != 0) & id_valid_i & (ex_rt_o == id_rs_i | ex_rt_o == id_rt_i).
REQ-015 SHALL drive stall_o = (load_use | hold_i) & ~flush_i, combinationally, zero latency.
REQ-016 SHALL update registers per edge with priority flush_i > hold_i > load_use > normal load.
REQ-017 Flush: SHALL clear ex_valid_o, ex_ctrl_o, and all data/index outputs to 0 next edge.
REQ-018 Hold: SHALL retain every output register, including bubble_cnt_o.
REQ-019 Load-use: SHALL insert bubble (ex_valid_o=0, ex_ctrl_o=0, data/index zeroed) and increment bubble_cnt_o by 1.
REQ-020 Normal load: SHALL capture all id_* inputs, ex_valid_o = id_valid_i; ex_ctrl_o SHALL be 0 when id_valid_i=0.
REQ-021 Latency SHALL be exactly one cycle ID input to EX output.
REQ-022 bubble_cnt_o SHALL saturate at 16'hFFFF, never wrap.
REQ-023 Bubble SHALL last exactly one cycle per load-use: after bubble, ex_ctrl_o.MemRead=0 so load_use deasserts.
REQ-024 flush_i concurrent with load_use SHALL flush only, no count increment; stall_o=0.
REQ-025 load_use SHALL ignore register index 0 (no stall on $zero).

Reset
REQ-026 rst_i low SHALL immediately clear all outputs registers, including bubble_cnt_o, to 0, independent of clk_i.
REQ-027 Reset mid-hold or mid-bubble SHALL abandon that state; first edge after release performs normal priority evaluation.

Structure
REQ-028 Shared package SHALL hold DATA_W, CTRL_W, ctrl bit-index constants (CTRL_REGWRITE..CTRL_ALUOP_LSB) and register-index width 5.
REQ-029 Load-use compare SHALL live in one combinational sub-module, hazard_detect; register logic stays in id_ex_pipe.

Verification
REQ-030 Normal: id_valid_i=1, id_imm_i=32'hFFFF_FFFC, id_ctrl_i=10'b1000110010 -> next edge ex_imm_o=32'hFFFF_FFFC, ex_ctrl_o equal, ex_valid_o=1, stall_o=0.
REQ-031 Load-use: EX holds lw rt=8 (MemRead=1); ID add rs=8 -> stall_o=1 same cycle; next edge ex_valid_o=0, ex_ctrl_o=0, bubble_cnt_o=1; following edge add enters EX, stall_o=0.
REQ-032 $zero: EX lw rt=0, ID rs=0 -> stall_o=0, no bubble, bubble_cnt_o unchanged.
REQ-033 Flush+load_use same cycle -> stall_o=0, next edge all outputs 0, bubble_cnt_o unchanged; hold_i=1 for 3 cycles -> outputs and stall_o=1 stable, then resume.
REQ-034 Saturation/reset: force bubble_cnt_o to 16'hFFFE, two load-use bubbles -> 16'hFFFF twice; drop rst_i mid-cycle -> all outputs 0 before next clk_i edge.
